text_console_ctrl: RTL and testbench

- Parametrised character-terminal controller: takes a stream of 8-bit character/control codes and maintains the cursor position.
- Writes glyph codes into an external COLS x ROWS character RAM.
- Provides hardware scrolling through a circular top-row offset and clears lines/screen with a sequencer.
- Sits between the PS/2 scancode-to-ASCII path and the VGA text renderer. The renderer adds row_top to its row index, modulo ROWS.

---
 rtl/text_console_pkg.sv | 25 ++
 rtl/text_console_clr_seq.sv | 60 ++++++
 rtl/text_console_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_text_console_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/text_console_pkg.sv
// text_console_pkg: control codes, FSM state type and blank fill
// shared by the text console controller and its clear sequencer.
package text_console_pkg;

  localparam logic [7:0] CC_BS    = 8'h08;
  localparam logic [7:0] CC_TAB   = 8'h09;
  localparam logic [7:0] CC_LF    = 8'h0A;
  localparam logic [7:0] CC_FF    = 8'h0C;
  localparam logic [7:0] CC_CR    = 8'h0D;
  localparam logic [7:0] CC_UP    = 8'h11;
  localparam logic [7:0] CC_DOWN  = 8'h12;
  localparam logic [7:0] CC_LEFT  = 8'h13;
  localparam logic [7:0] CC_RIGHT = 8'h14;

  localparam logic [7:0] PRINT_LO  = 8'h20;
  localparam logic [7:0] PRINT_HI  = 8'h7E;
  localparam logic [7:0] BLANK_DEF = 8'h20;

  typedef enum logic [1:0] {
    IDLE,
    CLR_LINE,
    CLR_SCREEN
  } state_t;

endpackage

// File: rtl/text_console_clr_seq.sv
// text_console_clr_seq: row/column sweep counter that walks one row
// or the whole screen, producing one clear address per cycle.
module text_console_clr_seq
  import text_console_pkg::*;
#(
  parameter int COLS = 80,
  parameter int ROWS = 30,
  parameter int X_W  = 7,
  parameter int Y_W  = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic               i_single_row,
  input  logic [Y_W-1:0]     i_row,
  output logic [Y_W+X_W-1:0] o_addr,
  output logic               o_en,
  output logic               o_done
);

  localparam logic [X_W-1:0] XMAX = X_W'(COLS - 1);
  localparam logic [Y_W-1:0] YMAX = Y_W'(ROWS - 1);

  logic           r_act;
  logic           r_single;
  logic [Y_W-1:0] r_row;
  logic [X_W-1:0] r_col;
  logic           w_last_col;
  logic           w_last_row;

  assign w_last_col = (r_col == XMAX);
  assign w_last_row = r_single | (r_row == YMAX);
  assign o_done     = r_act & w_last_col & w_last_row;
  assign o_en       = r_act;
  assign o_addr     = {r_row, r_col};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_act    <= 1'b0;
      r_single <= 1'b0;
      r_row    <= '0;
      r_col    <= '0;
    end else if (i_start) begin
      r_act    <= 1'b1;
      r_single <= i_single_row;
      r_row    <= i_row;
      r_col    <= '0;
    end else if (r_act) begin
      if (o_done) begin
        r_act <= 1'b0;
      end else if (w_last_col) begin
        r_col <= '0;
        r_row <= r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/text_console_ctrl.sv
// text_console_ctrl: character terminal with cursor, scroll and clears.
// Optional TEXT_CONSOLE_TAB_EN adds 0x09 tab stops every 8 columns.
module text_console_ctrl
  import text_console_pkg::*;
#(
  parameter int COLS   = 80,
  parameter int ROWS   = 30,
  parameter int X_W    = 7,
  parameter int Y_W    = 5,
  parameter int CHAR_W = 8,
  parameter logic [CHAR_W-1:0] BLANK = CHAR_W'(BLANK_DEF)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ch_valid,
  output logic               ch_ready,
  input  logic [CHAR_W-1:0]  ch_data,
  output logic               wr_en,
  output logic [Y_W+X_W-1:0] wr_addr,
  output logic [CHAR_W-1:0]  wr_data,
  output logic [X_W-1:0]     cursor_x,
  output logic [Y_W-1:0]     cursor_y,
  output logic [Y_W-1:0]     row_top,
  output logic               busy
);

  localparam int YW1 = Y_W + 1;
  localparam logic [X_W-1:0] XMAX = X_W'(COLS - 1);
  localparam logic [Y_W-1:0] YMAX = Y_W'(ROWS - 1);

  state_t              r_state;
  logic [X_W-1:0]      r_x;
  logic [Y_W-1:0]      r_y;
  logic [Y_W-1:0]      r_top;
  logic                r_we;
  logic [Y_W+X_W-1:0]  r_addr;
  logic [CHAR_W-1:0]   r_data;

  state_t              w_state_n;
  logic [X_W-1:0]      w_x_n;
  logic [Y_W-1:0]      w_y_n;
  logic [Y_W-1:0]      w_top_n;
  logic                w_we_n;
  logic [Y_W+X_W-1:0]  w_addr_n;
  logic [CHAR_W-1:0]   w_data_n;
  logic                w_nl;
  logic                w_start;
  logic                w_single;
  logic [Y_W-1:0]      w_tgt;

  logic                w_acc;
  logic [Y_W:0]        w_sum;
  logic [Y_W:0]        w_sub;
  logic [Y_W-1:0]      w_phys;
  logic [X_W-1:0]      w_x_dec;
  logic                w_print;

  logic [Y_W+X_W-1:0]  w_seq_addr;
  logic                w_seq_en;
  logic                w_seq_done;

  assign ch_ready = (r_state == IDLE);
  assign busy     = ~ch_ready;
  assign w_acc    = ch_valid & ch_ready;
  assign wr_en    = r_we;
  assign wr_addr  = r_addr;
  assign wr_data  = r_data;
  assign cursor_x = r_x;
  assign cursor_y = r_y;
  assign row_top  = r_top;

  // Logical-to-physical row without a divider: both terms are < ROWS.
  assign w_sum   = {1'b0, r_y} + {1'b0, r_top};
  assign w_sub   = w_sum - YW1'(ROWS);
  assign w_phys  = (w_sum >= YW1'(ROWS)) ? w_sub[Y_W-1:0]
                                         : w_sum[Y_W-1:0];
  assign w_x_dec = r_x - 1'b1;
  assign w_print = (ch_data >= CHAR_W'(PRINT_LO)) &&
                   (ch_data <= CHAR_W'(PRINT_HI));

`ifdef TEXT_CONSOLE_TAB_EN
  localparam int XT = X_W + 4;
  logic [XT-1:0] w_tab;
  assign w_tab = (XT'(r_x) | XT'(7)) + XT'(1);
`endif

  text_console_clr_seq #(
    .COLS (COLS),
    .ROWS (ROWS),
    .X_W  (X_W),
    .Y_W  (Y_W)
  ) u_clr_seq (
    .clk          (clk),
    .rst          (rst),
    .i_start      (w_start),
    .i_single_row (w_single),
    .i_row        (w_tgt),
    .o_addr       (w_seq_addr),
    .o_en         (w_seq_en),
    .o_done       (w_seq_done)
  );

  always_comb begin
    w_state_n = r_state;
    w_x_n     = r_x;
    w_y_n     = r_y;
    w_top_n   = r_top;
    w_we_n    = 1'b0;
    w_addr_n  = r_addr;
    w_data_n  = r_data;
    w_nl      = 1'b0;
    w_start   = 1'b0;
    w_single  = 1'b0;
    w_tgt     = r_top;
    unique case (r_state)
      IDLE: begin
        if (w_acc) begin
          if (w_print) begin
            w_we_n   = 1'b1;
            w_addr_n = {w_phys, r_x};
            w_data_n = ch_data;
            if (r_x < XMAX) w_x_n = r_x + 1'b1;
            else            w_nl  = 1'b1;
          end else begin
            case (ch_data)
              CC_LF, CC_CR: w_nl = 1'b1;
              CC_BS: begin
                if (r_x != '0) begin
                  w_x_n    = w_x_dec;
                  w_we_n   = 1'b1;
                  w_addr_n = {w_phys, w_x_dec};
                  w_data_n = BLANK;
                end
              end
              CC_UP:
                w_y_n = (r_y == '0) ? YMAX : r_y - 1'b1;
              CC_DOWN:
                w_y_n = (r_y == YMAX) ? '0 : r_y + 1'b1;
              CC_LEFT:
                w_x_n = (r_x == '0) ? XMAX : r_x - 1'b1;
              CC_RIGHT:
                w_x_n = (r_x == XMAX) ? '0 : r_x + 1'b1;
              CC_FF: begin
                w_x_n     = '0;
                w_y_n     = '0;
                w_top_n   = '0;
                w_state_n = CLR_SCREEN;
                w_start   = 1'b1;
                w_tgt     = '0;
              end
`ifdef TEXT_CONSOLE_TAB_EN
              CC_TAB: begin
                if (w_tab >= XT'(COLS)) w_nl  = 1'b1;
                else                    w_x_n = w_tab[X_W-1:0];
              end
`endif
              default: ;
            endcase
          end
          if (w_nl) begin
            w_x_n = '0;
            if (r_y < YMAX) begin
              w_y_n = r_y + 1'b1;
            end else begin
              // Scroll: the old top row becomes the new bottom row.
              w_top_n   = (r_top == YMAX) ? '0 : r_top + 1'b1;
              w_state_n = CLR_LINE;
              w_start   = 1'b1;
              w_single  = 1'b1;
              w_tgt     = r_top;
            end
          end
        end
      end
      CLR_LINE, CLR_SCREEN: begin
        w_we_n   = w_seq_en;
        w_addr_n = w_seq_addr;
        w_data_n = BLANK;
        if (w_seq_done) w_state_n = IDLE;
      end
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_top   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_n;
      r_x     <= w_x_n;
      r_y     <= w_y_n;
      r_top   <= w_top_n;
      r_we    <= w_we_n;
      r_addr  <= w_addr_n;
      r_data  <= w_data_n;
    end
  end

endmodule

// File: tb/tb_text_console_ctrl.sv
// tb_text_console_ctrl: directed stimulus with a write scoreboard
// checked by an independent monitor on the falling edge.
module tb_text_console_ctrl;
  import text_console_pkg::*;

  localparam int COLS = 80;
  localparam int ROWS = 30;
  localparam int X_W  = 7;
  localparam int Y_W  = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              ch_valid = 1'b0;
  logic [7:0]        ch_data = 8'h00;
  logic              ch_ready;
  logic              wr_en;
  logic [Y_W+X_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic [X_W-1:0]    cursor_x;
  logic [Y_W-1:0]    cursor_y;
  logic [Y_W-1:0]    row_top;
  logic              busy;

  int n_chk  = 0;
  int n_fail = 0;
  logic [19:0] exp_q[$];

  text_console_ctrl #(
    .COLS(COLS), .ROWS(ROWS), .X_W(X_W), .Y_W(Y_W), .CHAR_W(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ch_valid (ch_valid),
    .ch_ready (ch_ready),
    .ch_data  (ch_data),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .cursor_x (cursor_x),
    .cursor_y (cursor_y),
    .row_top  (row_top),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_cur(input string nm, input int x, input int y,
                         input int top);
    chk({nm, "_x"}, 32'(cursor_x), x);
    chk({nm, "_y"}, 32'(cursor_y), y);
    chk({nm, "_top"}, 32'(row_top), top);
  endtask

  task automatic push_wr(input int row, input int col, input int d);
    exp_q.push_back({row[4:0], col[6:0], d[7:0]});
  endtask

  task automatic send(input logic [7:0] c);
    int n;
    n = 0;
    @(negedge clk);
    ch_valid = 1'b1;
    ch_data  = c;
    while (!ch_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: code 0x%0h never accepted", c);
    end
    @(posedge clk);
    #1;
    ch_valid = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    @(negedge clk);
    while (busy && n < 5000) begin
      n++;
      @(negedge clk);
    end
  endtask

  always @(negedge clk) begin
    logic [19:0] e;
    if (!rst && wr_en) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h",
                 wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        if ({wr_addr, wr_data} !== e) begin
          n_fail++;
          $display("FAIL write: got addr 0x%0h data 0x%0h, expected addr 0x%0h data 0x%0h",
                   wr_addr, wr_data, e[19:8], e[7:0]);
        end
      end
      n_chk++;
      if (wr_addr[6:0] >= 7'(COLS)) begin
        n_fail++;
        $display("FAIL col_range: got col %0d, required < %0d",
                 wr_addr[6:0], COLS);
      end
    end
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk_cur("rst", 0, 0, 0);
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_wr_addr", 32'(wr_addr), 0);
    chk("rst_wr_data", 32'(wr_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(ch_ready), 1);
    @(negedge clk);
    rst = 1'b0;

    push_wr(0, 0, 'h41);
    send(8'h41);
    chk("A_latency", 32'(wr_en), 1);
    push_wr(0, 1, 'h42);
    send(8'h42);
    chk("B_latency", 32'(wr_en), 1);
    chk_cur("AB", 2, 0, 0);

    repeat (3) send(CC_LEFT);
    send(CC_UP);
    chk_cur("preZ", 79, 29, 0);
    push_wr(29, 79, 'h5A);
    for (int c = 0; c < COLS; c++) push_wr(0, c, 'h20);
    send(8'h5A);
    chk("Z_busy", 32'(busy), 1);
    chk("Z_ready", 32'(ch_ready), 0);
    chk_cur("postZ", 0, 29, 1);
    count_busy(n);
    chk("clr_line_cycles", n, COLS);

    repeat (6) send(CC_DOWN);
    chk_cur("at_0_5", 0, 5, 1);
    send(CC_LEFT);
    chk_cur("left_wrap", 79, 5, 1);
    repeat (6) send(CC_UP);
    chk_cur("up_wrap", 79, 29, 1);
    send(CC_RIGHT);
    chk_cur("right_wrap", 0, 29, 1);
    send(CC_BS);
    chk_cur("bs_at_0", 0, 29, 1);
    send(CC_RIGHT);
    push_wr(0, 0, 'h20);
    send(CC_BS);
    chk_cur("bs_move", 0, 29, 1);

    push_wr(0, 0, 'h43);
    send(8'h43);
    chk_cur("C_wrapped_row", 1, 29, 1);
    for (int c = 0; c < COLS; c++) push_wr(1, c, 'h20);
    send(CC_CR);
    chk_cur("cr_scroll", 0, 29, 2);
    count_busy(n);
    chk("clr_line2_cycles", n, COLS);
    send(8'h01);
    chk_cur("other_code", 0, 29, 2);
    for (int c = 0; c < COLS; c++) push_wr(2, c, 'h20);
    send(CC_LF);
    chk_cur("lf_scroll", 0, 29, 3);
    count_busy(n);
    chk("clr_line3_cycles", n, COLS);

    repeat (10) send(CC_RIGHT);
    repeat (11) send(CC_DOWN);
    chk_cur("pre_ff", 10, 10, 3);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) push_wr(r, c, 'h20);
    send(CC_FF);
    chk_cur("ff", 0, 0, 0);
    count_busy(n);
    chk("clr_screen_cycles", n, ROWS * COLS);
    push_wr(0, 0, 'h44);
    send(8'h44);
    chk_cur("D", 1, 0, 0);
    repeat (2) send(CC_RIGHT);
`ifdef TEXT_CONSOLE_TAB_EN
    send(CC_TAB);
    chk_cur("tab_8", 8, 0, 0);
    repeat (69) send(CC_RIGHT);
    chk_cur("pre_tab_nl", 77, 0, 0);
    send(CC_TAB);
    chk_cur("tab_nl", 0, 1, 0);
`else
    send(CC_TAB);
    chk_cur("tab_off", 3, 0, 0);
`endif

    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) push_wr(r, c, 'h20);
    send(CC_FF);
    repeat (20) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_cur("mid_rst", 0, 0, 0);
    chk("mid_rst_wr_en", 32'(wr_en), 0);
    chk("mid_rst_wr_addr", 32'(wr_addr), 0);
    chk("mid_rst_wr_data", 32'(wr_data), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_ready", 32'(ch_ready), 1);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_ready", 32'(ch_ready), 1);
    chk("post_rst_busy", 32'(busy), 0);
    repeat (2) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
